hash_bcd_converter: RTL and testbench



---
 rtl/hash_bcd_converter.sv | 100 ++++++++++
 tb/tb_hash_bcd_converter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hash_bcd_converter.sv
// hash_bcd_converter: sequential binary-to-BCD converter (shift-and-add-3).
// Converts a WIDTH-bit binary value into five BCD digits over WIDTH+1 cycles
// using a start/busy/done handshake. Outputs hold the last completed result.
module hash_bcd_converter #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             sysclk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] bin_in,
    output logic             busy,
    output logic             done,
    output logic [3:0]       D5_out,
    output logic [3:0]       D4_out,
    output logic [3:0]       D3_out,
    output logic [3:0]       D2_out,
    output logic [3:0]       D1_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shift_reg;
    logic [19:0]      scratch;
    logic [CNT_W-1:0] cnt;

    logic [19:0]      scratch_adj;
    logic [19:0]      scratch_next;
    logic [WIDTH-1:0] shift_next;

    // One double-dabble step: add 3 to every digit >= 5, then shift left by one
    always_comb begin
        scratch_adj = scratch;
        for (int unsigned i = 0; i < 5; i++) begin
            if (scratch[4*i +: 4] >= 4'd5) begin
                scratch_adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
            end
        end
        scratch_next = {scratch_adj[18:0], shift_reg[WIDTH-1]};
        shift_next   = shift_reg << 1;
    end

    // Control FSM with datapath registers and registered handshake outputs
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            shift_reg <= '0;
            scratch   <= '0;
            cnt       <= '0;
            D5_out    <= '0;
            D4_out    <= '0;
            D3_out    <= '0;
            D2_out    <= '0;
            D1_out    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        shift_reg <= bin_in;
                        scratch   <= '0;
                        cnt       <= '0;
                        state     <= SHIFT;
                        busy      <= 1'b1;
                    end
                end
                SHIFT: begin
                    scratch   <= scratch_next;
                    shift_reg <= shift_next;
                    cnt       <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    D5_out <= scratch[19:16];
                    D4_out <= scratch[15:12];
                    D3_out <= scratch[11:8];
                    D2_out <= scratch[7:4];
                    D1_out <= scratch[3:0];
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hash_bcd_converter.sv
// tb_hash_bcd_converter: directed self-checking bench for hash_bcd_converter.
module tb_hash_bcd_converter;

    logic        sysclk;
    logic        rst_n;
    logic        start;
    logic [15:0] bin_in;
    logic        busy;
    logic        done;
    logic [3:0]  D5_out, D4_out, D3_out, D2_out, D1_out;
    logic [19:0] digits;

    int checks   = 0;
    int failures = 0;

    hash_bcd_converter #(.WIDTH(16), .CNT_W(5)) dut (
        .sysclk (sysclk),
        .rst_n  (rst_n),
        .start  (start),
        .bin_in (bin_in),
        .busy   (busy),
        .done   (done),
        .D5_out (D5_out),
        .D4_out (D4_out),
        .D3_out (D3_out),
        .D2_out (D2_out),
        .D1_out (D1_out)
    );

    assign digits = {D5_out, D4_out, D3_out, D2_out, D1_out};

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    // Advance one clock; observe/drive 1 time unit after the rising edge
    task automatic cycle();
        @(posedge sysclk);
        #1;
    endtask

    // Clock until done is seen or the budget expires; reports cycles taken
    // and whether busy ever dropped before done
    task automatic wait_done(output int n, output bit busy_gap);
        n = 0;
        busy_gap = 1'b0;
        while (!done && n < 40) begin
            if (!busy) busy_gap = 1'b1;
            cycle();
            n++;
        end
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        start  = 1'b0;
        bin_in = '0;
        #12;
        checks++;
        if ({busy, done} !== 2'b00) begin
            failures++;
            $display("FAIL reset_flags busy/done=%b required 00", {busy, done});
        end
        checks++;
        if (digits !== 20'h00000) begin
            failures++;
            $display("FAIL reset_digits got %h required 00000", digits);
        end
        cycle();
        rst_n = 1'b1;
        cycle();
    endtask

    task automatic test_max();
        int n;
        bit gap;
        start = 1'b1;
        bin_in = 16'd65535;
        cycle();
        start = 1'b0;
        wait_done(n, gap);
        checks++;
        if (n !== 17) begin
            failures++;
            $display("FAIL max_latency got %0d required 17", n);
        end
        checks++;
        if (gap !== 1'b0) begin
            failures++;
            $display("FAIL max_busy_gap got %b required 0", gap);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL max_busy_with_done got %b required 0", busy);
        end
        checks++;
        if (digits !== 20'h65535) begin
            failures++;
            $display("FAIL max_digits got %h required 65535", digits);
        end
        cycle();
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL max_done_pulse_width got %b required 0", done);
        end
    endtask

    task automatic test_values();
        int n;
        bit gap;
        start = 1'b1;
        bin_in = 16'd16431;
        cycle();
        start = 1'b0;
        wait_done(n, gap);
        checks++;
        if (digits !== 20'h16431) begin
            failures++;
            $display("FAIL val16431_digits got %h required 16431", digits);
        end
        cycle();
        start = 1'b1;
        bin_in = 16'd0;
        cycle();
        start = 1'b0;
        cycle();
        cycle();
        checks++;
        if (digits !== 20'h16431) begin
            failures++;
            $display("FAIL hold_during_busy got %h required 16431", digits);
        end
        wait_done(n, gap);
        checks++;
        if (n !== 15) begin
            failures++;
            $display("FAIL zero_latency got %0d required 15 (17 total)", n);
        end
        checks++;
        if (digits !== 20'h00000) begin
            failures++;
            $display("FAIL zero_digits got %h required 00000", digits);
        end
        cycle();
    endtask

    task automatic test_back_to_back();
        int n;
        bit gap;
        start = 1'b1;
        bin_in = 16'd9999;
        cycle();
        bin_in = 16'd10000;
        wait_done(n, gap);
        checks++;
        if (digits !== 20'h09999) begin
            failures++;
            $display("FAIL b2b_first_digits got %h required 09999", digits);
        end
        cycle();
        checks++;
        if ({busy, done} !== 2'b10) begin
            failures++;
            $display("FAIL b2b_accept busy/done=%b required 10", {busy, done});
        end
        bin_in = 16'd5555;
        wait_done(n, gap);
        start = 1'b0;
        checks++;
        if (n + 1 !== 18) begin
            failures++;
            $display("FAIL b2b_spacing got %0d required 18", n + 1);
        end
        checks++;
        if (digits !== 20'h10000) begin
            failures++;
            $display("FAIL b2b_second_digits got %h required 10000", digits);
        end
        cycle();
        checks++;
        if ({busy, done} !== 2'b00) begin
            failures++;
            $display("FAIL b2b_idle busy/done=%b required 00", {busy, done});
        end
    endtask

    task automatic test_ignore_start();
        int n;
        start = 1'b1;
        bin_in = 16'd12345;
        cycle();
        start = 1'b0;
        n = 0;
        while (!done && n < 40) begin
            if (n == 3 || n == 10) begin
                start = 1'b1;
                bin_in = 16'd54321;
            end else begin
                start = 1'b0;
            end
            cycle();
            n++;
        end
        start = 1'b0;
        checks++;
        if (n !== 17) begin
            failures++;
            $display("FAIL ignore_latency got %0d required 17", n);
        end
        checks++;
        if (digits !== 20'h12345) begin
            failures++;
            $display("FAIL ignore_digits got %h required 12345", digits);
        end
        cycle();
        checks++;
        if ({busy, done} !== 2'b00) begin
            failures++;
            $display("FAIL ignore_idle busy/done=%b required 00", {busy, done});
        end
    endtask

    task automatic test_abort();
        int n;
        bit gap;
        int seen_done;
        start = 1'b1;
        bin_in = 16'd4095;
        cycle();
        start = 1'b0;
        wait_done(n, gap);
        checks++;
        if (digits !== 20'h04095) begin
            failures++;
            $display("FAIL abort_pre_digits got %h required 04095", digits);
        end
        cycle();
        start = 1'b1;
        bin_in = 16'd777;
        cycle();
        start = 1'b0;
        for (int i = 0; i < 8; i++) cycle();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done} !== 2'b00) begin
            failures++;
            $display("FAIL abort_flags busy/done=%b required 00", {busy, done});
        end
        checks++;
        if (digits !== 20'h00000) begin
            failures++;
            $display("FAIL abort_digits got %h required 00000", digits);
        end
        cycle();
        cycle();
        rst_n = 1'b1;
        seen_done = 0;
        for (int i = 0; i < 25; i++) begin
            cycle();
            if (done || busy) seen_done++;
        end
        checks++;
        if (seen_done !== 0) begin
            failures++;
            $display("FAIL abort_no_done got %0d active cycles required 0", seen_done);
        end
        start = 1'b1;
        bin_in = 16'd777;
        cycle();
        start = 1'b0;
        wait_done(n, gap);
        checks++;
        if (n !== 17) begin
            failures++;
            $display("FAIL after_abort_latency got %0d required 17", n);
        end
        checks++;
        if (digits !== 20'h00777) begin
            failures++;
            $display("FAIL after_abort_digits got %h required 00777", digits);
        end
        cycle();
    endtask

    initial begin
        test_reset();
        test_max();
        test_values();
        test_back_to_back();
        test_ignore_start();
        test_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
